// File: rtl/exit_gate_controller_if.sv
// ----------------------------------------------------------------------------
// exit_gate_controller_if
// Groups the exit-request handshake and the event-record output of the exit
// gate into one bundle.
//   ex_valid / ex_ready / ex_flat : exit request (requester -> gate)
//   evt_valid / evt_code / evt_flat : one-cycle event record (gate -> logger)
// Modports:
//   master : requester/logger side
//   slave  : exit gate controller side
// ----------------------------------------------------------------------------
interface exit_gate_controller_if #(
  parameter int FW = 5
);
  logic          ex_valid;
  logic          ex_ready;
  logic [FW-1:0] ex_flat;
  logic          evt_valid;
  logic [1:0]    evt_code;
  logic [FW-1:0] evt_flat;

  modport master (
    output ex_valid, ex_flat,
    input  ex_ready, evt_valid, evt_code, evt_flat
  );

  modport slave (
    input  ex_valid, ex_flat,
    output ex_ready, evt_valid, evt_code, evt_flat
  );
endinterface

// File: rtl/exit_gate_controller.sv
// ----------------------------------------------------------------------------
// exit_gate_controller
// Exit-gate stage of the car-parking system. Accepts exit requests for a flat,
// checks the slot-occupancy bitmap, opens the barrier for a valid request and
// waits (bounded) for the vehicle-clear sensor. Every request yields exactly
// one event record.
// Ports:
//   clk            : system clock, rising edge
//   rst_n          : asynchronous active-low reset
//   ent_valid_i    : entry side sets ent_flat_i occupied this cycle
//   ent_flat_i     : flat number for the entry set (0 or > N ignored)
//   sensor_clear_i : vehicle has passed the barrier (used only while open)
//   barrier_open_o : exit barrier drive
//   occ_o          : occupancy bitmap, bit k = flat k, bit 0 always 0
//   free_count_o   : number of free slots among flats 1..N
//   bus            : exit request handshake and event record (slave side)
// Event codes: 0 exited, 1 slot already empty, 2 flat out of range, 3 timeout.
// ----------------------------------------------------------------------------
module exit_gate_controller #(
  parameter int N       = 16,
  parameter int TIMEOUT = 1000,
  parameter int FW      = $clog2(N + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ent_valid_i,
  input  logic [FW-1:0]           ent_flat_i,
  input  logic                    sensor_clear_i,
  output logic                    barrier_open_o,
  output logic [N:0]              occ_o,
  output logic [FW-1:0]           free_count_o,
  exit_gate_controller_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    OPEN   = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t        state_q;
  logic [FW-1:0] flat_q;
  logic [TW-1:0] timer_q;
  logic [N:0]    occ_q;
  logic          ex_ready_q;
  logic          barrier_open_q;
  logic          evt_valid_q;
  logic [1:0]    evt_code_q;
  logic [FW-1:0] evt_flat_q;

  logic          ent_ok_s;
  logic          flat_ok_s;
  logic [FW-1:0] free_count_s;

  // Range qualification of the entry-set flat and the latched request flat.
  always_comb begin
    ent_ok_s  = ent_valid_i && (ent_flat_i != {FW{1'b0}}) && (ent_flat_i <= FW'(N));
    flat_ok_s = (flat_q != {FW{1'b0}}) && (flat_q <= FW'(N));
  end

  // Free-slot count: N minus the number of occupied flats; cannot wrap.
  always_comb begin
    free_count_s = FW'(N);
    for (int k = 1; k <= N; k++) begin
      if (occ_q[k]) begin
        free_count_s = free_count_s - FW'(1);
      end else begin
        free_count_s = free_count_s;
      end
    end
  end

  // Gate FSM with registered outputs, occupancy bitmap and open-time timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      flat_q         <= {FW{1'b0}};
      timer_q        <= {TW{1'b0}};
      occ_q          <= {(N + 1){1'b0}};
      ex_ready_q     <= 1'b1;
      barrier_open_q <= 1'b0;
      evt_valid_q    <= 1'b0;
      evt_code_q     <= 2'd0;
      evt_flat_q     <= {FW{1'b0}};
    end else begin
      // Event strobe lasts exactly the REPORT cycle.
      evt_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.ex_valid && ex_ready_q) begin
            flat_q     <= bus.ex_flat;
            ex_ready_q <= 1'b0;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          if (!flat_ok_s) begin
            evt_valid_q <= 1'b1;
            evt_code_q  <= 2'd2;
            evt_flat_q  <= flat_q;
            state_q     <= REPORT;
          end else if (!occ_q[flat_q]) begin
            evt_valid_q <= 1'b1;
            evt_code_q  <= 2'd1;
            evt_flat_q  <= flat_q;
            state_q     <= REPORT;
          end else begin
            occ_q[flat_q]  <= 1'b0;
            timer_q        <= {TW{1'b0}};
            barrier_open_q <= 1'b1;
            state_q        <= OPEN;
          end
        end
        OPEN: begin
          // Sensor has priority over a timeout in the same cycle.
          if (sensor_clear_i) begin
            barrier_open_q <= 1'b0;
            timer_q        <= {TW{1'b0}};
            evt_valid_q    <= 1'b1;
            evt_code_q     <= 2'd0;
            evt_flat_q     <= flat_q;
            state_q        <= REPORT;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            // Vehicle never left: give the slot back.
            occ_q[flat_q]  <= 1'b1;
            barrier_open_q <= 1'b0;
            timer_q        <= {TW{1'b0}};
            evt_valid_q    <= 1'b1;
            evt_code_q     <= 2'd3;
            evt_flat_q     <= flat_q;
            state_q        <= REPORT;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        REPORT: begin
          ex_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          barrier_open_q <= 1'b0;
          ex_ready_q     <= 1'b1;
          state_q        <= IDLE;
        end
      endcase
      // Placed last so an entry set wins over a same-cycle clear.
      if (ent_ok_s) begin
        occ_q[ent_flat_i] <= 1'b1;
      end
    end
  end

  assign bus.ex_ready  = ex_ready_q;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_code  = evt_code_q;
  assign bus.evt_flat  = evt_flat_q;
  assign barrier_open_o = barrier_open_q;
  assign occ_o          = occ_q;
  assign free_count_o   = free_count_s;

endmodule

// File: tb/tb_exit_gate_controller.sv
// ----------------------------------------------------------------------------
// tb_exit_gate_controller
// Directed steps followed by randomized entry/exit traffic, checked against a
// transaction-level model of the slot map and the expected event per request.
// ----------------------------------------------------------------------------
module tb_exit_gate_controller;
  localparam int N  = 16;
  localparam int TO = 10;
  localparam int FW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ent_valid = 1'b0;
  logic [FW-1:0] ent_flat = '0;
  logic          sensor_clear = 1'b0;
  logic          barrier_open;
  logic [N:0]    occ;
  logic [FW-1:0] free_count;

  int n_pass  = 0;
  int n_total = 0;
  bit mocc [0:N];

  always #5 clk = ~clk;

  exit_gate_controller_if #(.FW(FW)) bus ();

  exit_gate_controller #(.N(N), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ent_valid_i    (ent_valid),
    .ent_flat_i     (ent_flat),
    .sensor_clear_i (sensor_clear),
    .barrier_open_o (barrier_open),
    .occ_o          (occ),
    .free_count_o   (free_count),
    .bus            (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    v = 32'd0;
    for (int k = 1; k <= N; k++) v[k] = mocc[k];
    return v;
  endfunction

  function automatic int model_free();
    int c;
    c = 0;
    for (int k = 1; k <= N; k++) if (!mocc[k]) c++;
    return c;
  endfunction

  task automatic check_map(input string tag);
    chk({tag, "_occ"}, 32'(occ), model_vec());
    chk({tag, "_free"}, 32'(free_count), 32'(model_free()));
  endtask

  task automatic do_entry(input int f);
    logic [31:0] fv;
    fv = f;
    @(negedge clk);
    ent_valid = 1'b1;
    ent_flat  = fv[FW-1:0];
    @(posedge clk);
    @(negedge clk);
    ent_valid = 1'b0;
    if (f >= 1 && f <= N) mocc[f] = 1'b1;
    check_map("entry");
  endtask

  // clr: OPEN cycle (1-based) in which sensor_clear is driven, 0 = never.
  // coll: drive an entry set of the same flat during the CHECK cycle.
  task automatic do_exit(input int f, input int clr, input bit coll);
    int code, olen;
    bit inr;
    logic [31:0] fv;
    fv  = f;
    inr = (f >= 1 && f <= N);
    if (!inr)                        code = 2;
    else if (!mocc[f])               code = 1;
    else if (clr >= 1 && clr <= TO)  code = 0;
    else                             code = 3;
    olen = (code == 0) ? clr : ((code == 3) ? TO : 0);

    @(negedge clk);
    chk("ready_idle", 32'(bus.ex_ready), 32'd1);
    bus.ex_valid = 1'b1;
    bus.ex_flat  = fv[FW-1:0];
    @(posedge clk);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    chk("ready_check", 32'(bus.ex_ready), 32'd0);
    chk("barrier_check", 32'(barrier_open), 32'd0);
    if (coll) begin
      ent_valid = 1'b1;
      ent_flat  = fv[FW-1:0];
    end
    @(posedge clk);
    @(negedge clk);
    ent_valid = 1'b0;
    for (int i = 1; i <= olen; i++) begin
      chk("barrier_open", 32'(barrier_open), 32'd1);
      chk("evt_in_open", 32'(bus.evt_valid), 32'd0);
      if (i == 1) chk("occ_first_open", 32'(occ[f]), coll ? 32'd1 : 32'd0);
      sensor_clear = (i == clr);
      @(posedge clk);
      @(negedge clk);
    end
    sensor_clear = 1'b0;
    if (code == 0 && !coll) mocc[f] = 1'b0;
    if (coll && inr) mocc[f] = 1'b1;
    chk("evt_valid", 32'(bus.evt_valid), 32'd1);
    chk("evt_code", 32'(bus.evt_code), 32'(code));
    chk("evt_flat", 32'(bus.evt_flat), 32'(fv[FW-1:0]));
    chk("barrier_report", 32'(barrier_open), 32'd0);
    check_map("exit");
    @(posedge clk);
    @(negedge clk);
    chk("ready_after", 32'(bus.ex_ready), 32'd1);
    chk("evt_single", 32'(bus.evt_valid), 32'd0);
  endtask

  initial begin
    bus.ex_valid = 1'b0;
    bus.ex_flat  = '0;
    for (int k = 0; k <= N; k++) mocc[k] = 1'b0;

    // Reset defaults while held in reset and after release.
    #1;
    chk("rst_barrier", 32'(barrier_open), 32'd0);
    chk("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
    chk("rst_evt_code", 32'(bus.evt_code), 32'd0);
    chk("rst_evt_flat", 32'(bus.evt_flat), 32'd0);
    check_map("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.ex_ready), 32'd1);
    chk("rst_free16", 32'(free_count), 32'd16);

    // Valid exit, clear on 4th open cycle.
    do_entry(5);
    chk("occ5_set", 32'(occ[5]), 32'd1);
    do_exit(5, 4, 1'b0);
    chk("free_back16", 32'(free_count), 32'd16);

    // Invalid requests.
    do_exit(7, 0, 1'b0);
    do_exit(0, 0, 1'b0);
    do_exit(17, 0, 1'b0);

    // Timeout, then clear in the last open cycle.
    do_entry(3);
    do_exit(3, 0, 1'b0);
    chk("occ3_restored", 32'(occ[3]), 32'd1);
    do_exit(3, TO, 1'b0);

    // Entry/clear collision on flat 9.
    do_entry(9);
    do_exit(9, 2, 1'b1);
    chk("occ9_kept", 32'(occ[9]), 32'd1);

    // Reset while the barrier is open.
    do_entry(12);
    @(negedge clk);
    bus.ex_valid = 1'b1;
    bus.ex_flat  = FW'(12);
    @(posedge clk);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_open", 32'(barrier_open), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_barrier", 32'(barrier_open), 32'd0);
    chk("midrst_occ", 32'(occ), 32'd0);
    chk("midrst_evt", 32'(bus.evt_valid), 32'd0);
    for (int k = 0; k <= N; k++) mocc[k] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_evt", 32'(bus.evt_valid), 32'd0);
      chk("postrst_ready", 32'(bus.ex_ready), 32'd1);
    end
    check_map("postrst");

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_entry(int'($urandom_range(0, 18)));
      end else begin
        do_exit(int'($urandom_range(0, 20)), int'($urandom_range(0, 12)),
                ($urandom_range(0, 3) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
